spike_rate_decoder: RTL and testbench

Converts a rate-coded spike train back into a WIDTH-bit magnitude by counting spikes over a fixed window of WINDOW clock cycles. It sits on the receive side of a spiking stage, for example behind a rate-encoding neuron or at a perceptron output. It returns the count as a binary value through a valid/ready output handshake. For a rate encoder driven with weight w and the default WINDOW, the decoded value equals w at both extremes: w=0 gives 0 and w=2^WIDTH−1 gives 2^WIDTH−1.

---
 rtl/spike_rate_decoder.sv | 96 +++++++++
 tb/tb_spike_rate_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_decoder.sv
// Rate-code decoder: counts spike_in highs over a WINDOW-cycle window and
// presents the saturating count through a valid/ready output handshake.
module spike_rate_decoder #(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             spike_in,
    output logic [WIDTH-1:0] value,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic             sat,
    output logic [1:0]       state_dbg
);

    localparam int WCW = $clog2(WINDOW + 1);
    localparam logic [WIDTH-1:0] SPK_MAX = '1;
    localparam logic [WCW-1:0] WIN_LAST = WCW'(WINDOW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WCW-1:0]   win_cnt;
    logic [WIDTH-1:0] spk_cnt, spk_nxt;
    logic             sat_nxt;
    logic             last_sample;
    logic             launch;

    // Handshake: a result transfers on any edge where valid & ready are both
    // high; value and sat stay frozen while valid is high and ready is low.
    always_comb begin
        state_nxt   = state;
        spk_nxt     = spk_cnt;
        sat_nxt     = sat;
        last_sample = (state == COUNT) && (win_cnt == WIN_LAST);
        launch      = 1'b0;
        busy        = (state == COUNT);
        valid       = (state == HOLD);
        state_dbg   = state;

        if (spike_in) begin
            if (spk_cnt == SPK_MAX) sat_nxt = 1'b1;
            else                    spk_nxt = spk_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = COUNT;
                    launch    = 1'b1;
                end
            end
            COUNT: begin
                if (last_sample) state_nxt = HOLD;
            end
            HOLD: begin
                if (ready) begin
                    state_nxt = start ? COUNT : IDLE;
                    launch    = start;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            win_cnt <= '0;
            spk_cnt <= '0;
            sat     <= 1'b0;
            value   <= '0;
        end else begin
            state <= state_nxt;
            if (launch) begin
                win_cnt <= '0;
                spk_cnt <= '0;
                sat     <= 1'b0;
            end else if (state == COUNT) begin
                win_cnt <= win_cnt + WCW'(1);
                spk_cnt <= spk_nxt;
                sat     <= sat_nxt;
                // Final sample is folded into the latched result on the same edge.
                if (last_sample) value <= spk_nxt;
            end
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Randomized bench for spike_rate_decoder: window-level reference model plus
// directed reset, backpressure, back-to-back and saturation scenarios.
module tb_spike_rate_decoder;

    localparam int W     = 8;
    localparam int WIN   = 255;
    localparam int WIN_B = 300;
    localparam int MAXV  = 255;

    logic         clk;
    logic         rst;
    logic         start, spike_in, ready;
    logic [W-1:0] value;
    logic         valid, busy, sat;
    logic [1:0]   state_dbg;

    logic         start_b, spike_b, ready_b;
    logic [W-1:0] value_b;
    logic         valid_b, busy_b, sat_b;
    logic [1:0]   state_dbg_b;

    int n_vec;
    int n_err;
    logic [W-1:0] exp_q[$];
    logic         exp_sat;

    spike_rate_decoder #(.WIDTH(W), .WINDOW(WIN)) dut (
        .clk(clk), .rst(rst), .start(start), .spike_in(spike_in),
        .value(value), .valid(valid), .ready(ready), .busy(busy),
        .sat(sat), .state_dbg(state_dbg)
    );

    spike_rate_decoder #(.WIDTH(W), .WINDOW(WIN_B)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .spike_in(spike_b),
        .value(value_b), .valid(valid_b), .ready(ready_b), .busy(busy_b),
        .sat(sat_b), .state_dbg(state_dbg_b)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change right after the falling edge; outputs are read there too.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic gen(input int mode, input int i);
        case (mode)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return (i % 2) == 0;
            3:       return (i % 4) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Called just after the start edge: drives WIN samples, then checks the result.
    task automatic count_phase(input int mode);
        int sum;
        sum = 0;
        for (int i = 0; i < WIN; i++) begin
            check("busy_in_window", busy, 1);
            check("valid_in_window", valid, 0);
            spike_in = gen(mode, i);
            start    = 1'($urandom_range(0, 1));
            ready    = 1'($urandom_range(0, 1));
            sum += int'(spike_in);
            cycle();
        end
        start   = 1'b0;
        ready   = 1'b0;
        exp_q.push_back((sum > MAXV) ? W'(MAXV) : W'(sum));
        exp_sat = (sum > MAXV);
        check("valid_after_window", valid, 1);
        check("busy_after_window", busy, 0);
        check("value", value, exp_q[0]);
        check("sat", sat, exp_sat);
    endtask

    task automatic launch(input int mode);
        start    = 1'b1;
        spike_in = 1'($urandom_range(0, 1));
        cycle();
        start = 1'b0;
        count_phase(mode);
    endtask

    task automatic drain(input int wait_cycles, input bit chain, input int next_mode);
        ready = 1'b0;
        for (int i = 0; i < wait_cycles; i++) begin
            start    = 1'($urandom_range(0, 1));
            spike_in = 1'($urandom_range(0, 1));
            cycle();
            check("valid_hold", valid, 1);
            check("value_hold", value, exp_q[0]);
            check("sat_hold", sat, exp_sat);
        end
        ready = 1'b1;
        start = chain;
        cycle();
        void'(exp_q.pop_front());
        ready = 1'b0;
        start = 1'b0;
        check("valid_after_accept", valid, 0);
        if (chain) begin
            count_phase(next_mode);
        end else begin
            check("busy_after_accept", busy, 0);
        end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        exp_sat  = 1'b0;
        rst      = 1'b0;
        start    = 1'b1;
        spike_in = 1'b1;
        ready    = 1'b0;
        start_b  = 1'b1;
        spike_b  = 1'b1;
        ready_b  = 1'b0;

        // reset held with start and spikes active
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("rst_value", value, 0);
            check("rst_valid", valid, 0);
            check("rst_busy", busy, 0);
            check("rst_sat", sat, 0);
        end
        rst     = 1'b1;
        start   = 1'b0;
        start_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("idle_busy", busy, 0);
            check("idle_valid", valid, 0);
        end

        // full, empty and fractional rates
        launch(0);
        drain(20, 1'b0, 0);
        launch(1);
        drain(0, 1'b0, 0);
        launch(2);
        drain(3, 1'b1, 3);
        drain(0, 1'b0, 0);

        // reset in the middle of a window
        launch(0);
        drain(0, 1'b0, 0);
        start    = 1'b1;
        spike_in = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 100; i++) cycle();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        check("abort_value", value, 0);
        check("abort_valid", valid, 0);
        check("abort_busy", busy, 0);
        check("abort_sat", sat, 0);
        for (int i = 0; i < WIN + 5; i++) begin
            cycle();
            check("abort_no_valid", valid, 0);
        end
        spike_in = 1'b0;
        launch(1);
        drain(1, 1'b0, 0);

        // randomized windows with random backpressure and chaining
        launch(4);
        for (int it = 0; it < 8; it++) begin
            int  nm;
            bit  ch;
            nm = $urandom_range(0, 4);
            ch = 1'($urandom_range(0, 1));
            drain($urandom_range(0, 4), ch, nm);
            if (!ch) launch(nm);
        end
        drain(0, 1'b0, 0);

        // saturation with a window longer than the counter range
        start_b = 1'b1;
        spike_b = 1'b1;
        cycle();
        start_b = 1'b0;
        for (int i = 0; i < WIN_B; i++) begin
            check("b_busy", busy_b, 1);
            cycle();
        end
        check("b_valid", valid_b, 1);
        check("b_value", value_b, MAXV);
        check("b_sat", sat_b, 1);
        ready_b = 1'b1;
        cycle();
        ready_b = 1'b0;
        check("b_valid_after_accept", valid_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
